// File: rtl/issue_dispatch_pkg.sv
// Shared encodings and helpers for the issue dispatch controller.
// FU class codes, default sizing and RS index mapping.
package issue_dispatch_pkg;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_LSU = 2'b01,
    CLS_BRU = 2'b10,
    CLS_EPU = 2'b11
  } fu_cls_e;

  localparam int DEF_PAYLOAD_W  = 128;
  localparam int DEF_NUM_ALU_RS = 2;

  // Non-ALU stations follow the ALU block in this order.
  localparam int RS_LSU_OFS = 0;
  localparam int RS_BRU_OFS = 1;
  localparam int RS_EPU_OFS = 2;

  function automatic int rs_index(input fu_cls_e cls, input int num_alu);
    int idx;
    case (cls)
      CLS_LSU: idx = num_alu + RS_LSU_OFS;
      CLS_BRU: idx = num_alu + RS_BRU_OFS;
      CLS_EPU: idx = num_alu + RS_EPU_OFS;
      default: idx = 0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/issue_dispatch_if.sv
// Rename-to-dispatch group handshake plus the per-RS push/full bundle.
interface issue_dispatch_if
  import issue_dispatch_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int NUM_RS    = DEF_NUM_ALU_RS + 3
);
  logic [1:0]                  dsp_valid;
  logic [3:0]                  dsp_cls;
  logic [2*PAYLOAD_W-1:0]      dsp_payload;
  logic                        dsp_ready;
  logic [NUM_RS-1:0]           rs_full;
  logic [NUM_RS-1:0]           rs_push;
  logic [NUM_RS*PAYLOAD_W-1:0] rs_payload;

  modport master (
    output dsp_valid, dsp_cls, dsp_payload, rs_full,
    input  dsp_ready, rs_push, rs_payload
  );

  modport slave (
    input  dsp_valid, dsp_cls, dsp_payload, rs_full,
    output dsp_ready, rs_push, rs_payload
  );
endinterface

// File: rtl/issue_dispatch_rr.sv
// Round-robin ALU RS selector: two in-order requesters, search from ptr upward.
module issue_dispatch_rr #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  alu_full,
  input  logic          req0,
  input  logic          req1,
  output logic [N-1:0]  gnt0,
  output logic [N-1:0]  gnt1,
  output logic [PW-1:0] ptr_nxt
);
  logic [2*N-1:0] free_dbl_s;
  logic [2*N-1:0] g0_dbl_s;
  logic [2*N-1:0] g1_dbl_s;
  logic [N-1:0]   free_rot_s;
  logic [N-1:0]   g0_rot_s;
  logic [N-1:0]   g1_rot_s;
  logic [N-1:0]   take0_s;
  logic [N-1:0]   take1_s;
  logic           found0_s;
  logic           found1_s;

  // Rotate so that bit 0 is the station ptr points at.
  assign free_dbl_s = {~alu_full, ~alu_full} >> ptr;
  assign free_rot_s = free_dbl_s[N-1:0];

  // Priority scan in rotated order; slot1 takes the first free station after slot0's.
  always_comb begin
    g0_rot_s = {N{1'b0}};
    g1_rot_s = {N{1'b0}};
    take0_s  = {N{1'b0}};
    take1_s  = {N{1'b0}};
    found0_s = 1'b0;
    found1_s = 1'b0;
    ptr_nxt  = ptr;
    for (int i = 0; i < N; i++) begin
      take0_s[i]  = free_rot_s[i] & req0 & ~found0_s;
      take1_s[i]  = free_rot_s[i] & req1 & ~found1_s & ~take0_s[i];
      g0_rot_s[i] = take0_s[i];
      g1_rot_s[i] = take1_s[i];
      found0_s    = found0_s | take0_s[i];
      found1_s    = found1_s | take1_s[i];
      ptr_nxt     = (take0_s[i] | take1_s[i]) ? PW'((int'(ptr) + i + 1) % N) : ptr_nxt;
    end
  end

  assign g0_dbl_s = {g0_rot_s, g0_rot_s} << ptr;
  assign g1_dbl_s = {g1_rot_s, g1_rot_s} << ptr;
  assign gnt0     = g0_dbl_s[2*N-1:N];
  assign gnt1     = g1_dbl_s[2*N-1:N];

endmodule

// File: rtl/issue_dispatch.sv
// Dispatch controller: 2-slot holding buffer steering renamed ops to RS instances,
// in-order within a group, with ALU round-robin balancing and a stall counter.
module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int PAYLOAD_W   = DEF_PAYLOAD_W,
  parameter int NUM_ALU_RS  = DEF_NUM_ALU_RS,
  parameter int NUM_RS      = NUM_ALU_RS + 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  issue_dispatch_if.slave        bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int PTR_W = $clog2(NUM_ALU_RS);

  logic [1:0]             vld_r;
  fu_cls_e                cls0_r, cls1_r;
  logic [PAYLOAD_W-1:0]   pld0_r, pld1_r;
  logic [PTR_W-1:0]       ptr_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic [NUM_ALU_RS-1:0]       alu_full_s, gnt0_s, gnt1_s;
  logic [PTR_W-1:0]            ptr_nxt_s;
  logic [NUM_RS-1:0]           tgt0_s, tgt1_s, sel0_s, sel1_s, push_s;
  logic [NUM_RS*PAYLOAD_W-1:0] pay_s;
  logic                        alu0_s, alu1_s, disp0_s, disp1_s, go1_s;
  logic                        req0_s, req1_s, ready_s, xfer_s, stall_s;

  assign alu0_s     = (cls0_r == CLS_ALU);
  assign alu1_s     = (cls1_r == CLS_ALU);
  assign alu_full_s = bus.rs_full[NUM_ALU_RS-1:0];

  // One-hot target for non-ALU classes (all-zero for ALU ops).
  always_comb begin
    tgt0_s = {NUM_RS{1'b0}};
    tgt1_s = {NUM_RS{1'b0}};
    for (int r = 0; r < NUM_RS; r++) begin
      tgt0_s[r] = !alu0_s && (r == rs_index(cls0_r, NUM_ALU_RS));
      tgt1_s[r] = !alu1_s && (r == rs_index(cls1_r, NUM_ALU_RS));
    end
  end

  // Slot0 ALU success only needs any free ALU station; keeps slot1's request free of grant feedback.
  assign disp0_s = vld_r[0] & (alu0_s ? ~&alu_full_s : |(tgt0_s & ~bus.rs_full));
  assign go1_s   = ~vld_r[0] | disp0_s;
  assign req0_s  = vld_r[0] & alu0_s;
  assign req1_s  = vld_r[1] & alu1_s & go1_s;
  assign disp1_s = vld_r[1] & go1_s &
                   (alu1_s ? |gnt1_s
                           : (|(tgt1_s & ~bus.rs_full)) & ~(vld_r[0] & (tgt0_s == tgt1_s)));

  issue_dispatch_rr #(.N(NUM_ALU_RS), .PW(PTR_W)) u_rr (
    .ptr      (ptr_r),
    .alu_full (alu_full_s),
    .req0     (req0_s),
    .req1     (req1_s),
    .gnt0     (gnt0_s),
    .gnt1     (gnt1_s),
    .ptr_nxt  (ptr_nxt_s)
  );

  assign sel0_s = alu0_s ? {{(NUM_RS-NUM_ALU_RS){1'b0}}, gnt0_s} : tgt0_s;
  assign sel1_s = alu1_s ? {{(NUM_RS-NUM_ALU_RS){1'b0}}, gnt1_s} : tgt1_s;
  assign push_s = flush ? {NUM_RS{1'b0}}
                        : (({NUM_RS{disp0_s}} & sel0_s) | ({NUM_RS{disp1_s}} & sel1_s));

  // Route each slot's payload to the station it pushes.
  always_comb begin
    pay_s = {(NUM_RS*PAYLOAD_W){1'b0}};
    for (int r = 0; r < NUM_RS; r++) begin
      pay_s[r*PAYLOAD_W +: PAYLOAD_W] = (disp1_s && sel1_s[r]) ? pld1_r : pld0_r;
    end
  end

  assign ready_s = ~flush & (~vld_r[0] | disp0_s) & (~vld_r[1] | disp1_s);
  assign xfer_s  = ready_s & (|bus.dsp_valid);
  assign stall_s = ~flush & ((vld_r[0] & ~disp0_s) | (vld_r[1] & ~disp1_s));

  assign bus.rs_push    = push_s;
  assign bus.rs_payload = pay_s;
  assign bus.dsp_ready  = ready_s;
  assign stall_cnt      = stall_cnt_r;

  // Holding buffer: load on transfer, otherwise retire dispatched slots in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r  <= 2'b00;
      cls0_r <= CLS_ALU;
      cls1_r <= CLS_ALU;
      pld0_r <= {PAYLOAD_W{1'b0}};
      pld1_r <= {PAYLOAD_W{1'b0}};
    end else if (flush) begin
      vld_r <= 2'b00;
    end else if (xfer_s) begin
      vld_r  <= bus.dsp_valid;
      cls0_r <= fu_cls_e'(bus.dsp_cls[1:0]);
      cls1_r <= fu_cls_e'(bus.dsp_cls[3:2]);
      pld0_r <= bus.dsp_payload[PAYLOAD_W-1:0];
      pld1_r <= bus.dsp_payload[2*PAYLOAD_W-1:PAYLOAD_W];
    end else begin
      vld_r <= vld_r & ~{disp1_s, disp0_s};
    end
  end

  // ALU pointer and saturating stall counter; both survive a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r       <= {PTR_W{1'b0}};
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else begin
      if (!flush) begin
        ptr_r <= ptr_nxt_s;
      end
      if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed self-checking bench for issue_dispatch (2 ALU RS, 128-bit payload).
module tb_issue_dispatch;
  import issue_dispatch_pkg::*;

  localparam int PW = 128;
  localparam int NA = 2;
  localparam int NR = 5;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [SW-1:0] stall_cnt;
  int            checks = 0;
  int            errors = 0;

  issue_dispatch_if #(.PAYLOAD_W(PW), .NUM_RS(NR)) bus();

  issue_dispatch #(
    .PAYLOAD_W(PW), .NUM_ALU_RS(NA), .NUM_RS(NR), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] mk(input logic [31:0] tag);
    return {tag, ~tag, tag ^ 32'h5A5A_5A5A, tag + 32'd1};
  endfunction

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0;
    bus.dsp_valid = 2'b00; bus.dsp_cls = 4'b0000;
    bus.dsp_payload = {(2*PW){1'b0}}; bus.rs_full = 5'b00000;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL reset_push: got %b want 00000", bus.rs_push); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.dsp_ready); end
    checks++; if (stall_cnt !== 16'h0000) begin errors++; $display("FAIL reset_stall: got %h want 0000", stall_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_alu_lsu;
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b0100; bus.dsp_payload = {mk(32'h11), mk(32'h10)};
    #1;
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", bus.dsp_ready); end
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b00101) begin errors++; $display("FAIL alu_lsu_push: got %b want 00101", bus.rs_push); end
    checks++; if (bus.rs_payload[0*PW +: PW] !== mk(32'h10)) begin errors++; $display("FAIL alu_lsu_pay0: got %h want %h", bus.rs_payload[0*PW +: PW], mk(32'h10)); end
    checks++; if (bus.rs_payload[2*PW +: PW] !== mk(32'h11)) begin errors++; $display("FAIL alu_lsu_pay2: got %h want %h", bus.rs_payload[2*PW +: PW], mk(32'h11)); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL alu_lsu_ready: got %b want 1", bus.dsp_ready); end
  endtask

  task automatic test_alu_rr;
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b0000; bus.dsp_payload = {mk(32'h21), mk(32'h20)};
    bus.rs_full = 5'b00010;
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b00001) begin errors++; $display("FAIL rr_slot0_push: got %b want 00001", bus.rs_push); end
    checks++; if (bus.rs_payload[0*PW +: PW] !== mk(32'h20)) begin errors++; $display("FAIL rr_slot0_pay: got %h want %h", bus.rs_payload[0*PW +: PW], mk(32'h20)); end
    checks++; if (bus.dsp_ready !== 1'b0) begin errors++; $display("FAIL rr_held_ready: got %b want 0", bus.dsp_ready); end
    @(negedge clk);
    bus.rs_full = 5'b00000;
    #1;
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rr_stall: got %0d want 1", stall_cnt); end
    checks++; if (bus.rs_push !== 5'b00010) begin errors++; $display("FAIL rr_slot1_push: got %b want 00010", bus.rs_push); end
    checks++; if (bus.rs_payload[1*PW +: PW] !== mk(32'h21)) begin errors++; $display("FAIL rr_slot1_pay: got %h want %h", bus.rs_payload[1*PW +: PW], mk(32'h21)); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL rr_release_ready: got %b want 1", bus.dsp_ready); end
  endtask

  task automatic test_same_rs;
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b1010; bus.dsp_payload = {mk(32'h31), mk(32'h30)};
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b01000) begin errors++; $display("FAIL bru_c1_push: got %b want 01000", bus.rs_push); end
    checks++; if (bus.rs_payload[3*PW +: PW] !== mk(32'h30)) begin errors++; $display("FAIL bru_c1_pay: got %h want %h", bus.rs_payload[3*PW +: PW], mk(32'h30)); end
    checks++; if (bus.dsp_ready !== 1'b0) begin errors++; $display("FAIL bru_c1_ready: got %b want 0", bus.dsp_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.rs_push !== 5'b01000) begin errors++; $display("FAIL bru_c2_push: got %b want 01000", bus.rs_push); end
    checks++; if (bus.rs_payload[3*PW +: PW] !== mk(32'h31)) begin errors++; $display("FAIL bru_c2_pay: got %h want %h", bus.rs_payload[3*PW +: PW], mk(32'h31)); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL bru_c2_ready: got %b want 1", bus.dsp_ready); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bru_stall: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_blocked_head;
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b1101; bus.dsp_payload = {mk(32'h41), mk(32'h40)};
    bus.rs_full = 5'b00100;
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL head_block_push[%0d]: got %b want 00000", i, bus.rs_push); end
      @(negedge clk);
    end
    bus.rs_full = 5'b00000;
    #1;
    checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL head_stall: got %0d want 7", stall_cnt); end
    checks++; if (bus.rs_push !== 5'b10100) begin errors++; $display("FAIL head_release_push: got %b want 10100", bus.rs_push); end
    checks++; if (bus.rs_payload[2*PW +: PW] !== mk(32'h40)) begin errors++; $display("FAIL head_pay_lsu: got %h want %h", bus.rs_payload[2*PW +: PW], mk(32'h40)); end
    checks++; if (bus.rs_payload[4*PW +: PW] !== mk(32'h41)) begin errors++; $display("FAIL head_pay_epu: got %h want %h", bus.rs_payload[4*PW +: PW], mk(32'h41)); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    bus.dsp_valid = 2'b01; bus.dsp_cls = 4'b0000; bus.dsp_payload = {mk(32'h0), mk(32'h50)};
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b00001) begin errors++; $display("FAIL flush_pre_push: got %b want 00001", bus.rs_push); end
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b0000; bus.dsp_payload = {mk(32'h52), mk(32'h51)};
    bus.rs_full = 5'b00011;
    @(negedge clk);
    bus.dsp_valid = 2'b01; bus.dsp_payload = {mk(32'h0), mk(32'h53)};
    flush = 1'b1;
    #1;
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL flush_push: got %b want 00000", bus.rs_push); end
    checks++; if (bus.dsp_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.dsp_ready); end
    @(negedge clk);
    flush = 1'b0; bus.rs_full = 5'b00000;
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL flush_empty_push: got %b want 00000", bus.rs_push); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", bus.dsp_ready); end
    checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL flush_stall_kept: got %0d want 7", stall_cnt); end
    bus.dsp_valid = 2'b01; bus.dsp_cls = 4'b0000; bus.dsp_payload = {mk(32'h0), mk(32'h54)};
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b00010) begin errors++; $display("FAIL flush_ptr_kept: got %b want 00010", bus.rs_push); end
    checks++; if (bus.rs_payload[1*PW +: PW] !== mk(32'h54)) begin errors++; $display("FAIL flush_post_pay: got %h want %h", bus.rs_payload[1*PW +: PW], mk(32'h54)); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.dsp_valid = 2'b11; bus.dsp_cls = 4'b1010; bus.dsp_payload = {mk(32'h61), mk(32'h60)};
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    #1;
    checks++; if (bus.rs_push !== 5'b01000) begin errors++; $display("FAIL midrst_pre_push: got %b want 01000", bus.rs_push); end
    rst = 1'b0;
    #1;
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL midrst_push: got %b want 00000", bus.rs_push); end
    checks++; if (bus.dsp_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.dsp_ready); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL midrst_after_push: got %b want 00000", bus.rs_push); end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    bus.dsp_valid = 2'b01; bus.dsp_cls = 4'b0001; bus.dsp_payload = {mk(32'h0), mk(32'h70)};
    bus.rs_full = 5'b00100;
    @(negedge clk);
    bus.dsp_valid = 2'b00;
    repeat (100) @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 16'd100) begin errors++; $display("FAIL sat_count100: got %0d want 100", stall_cnt); end
    repeat (65435) @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    checks++; if (bus.rs_push !== 5'b00000) begin errors++; $display("FAIL sat_push: got %b want 00000", bus.rs_push); end
    bus.rs_full = 5'b00000;
    #1;
    checks++; if (bus.rs_push !== 5'b00100) begin errors++; $display("FAIL sat_release_push: got %b want 00100", bus.rs_push); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu_lsu();
    test_alu_rr();
    test_same_rs();
    test_blocked_head();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
